// File: rtl/accel_pkg.sv
// Shared constants and types for the weight feeder / multiplier array.
package accel_pkg;

  localparam int unsigned LANES = 16;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned IDX_W = $clog2(WIDTH);

  typedef logic [WIDTH-1:0] weight_t;
  typedef weight_t [LANES-1:0] weight_vec_t;

  typedef enum logic {IDLE, SHIFT} state_t;

endpackage

// File: rtl/lane_shifter.sv
// One lane's active weight register: parallel load, shift right, bit 0 out.
module lane_shifter
  import accel_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    i_load,
  input  logic    i_shift,
  input  weight_t i_data,
  output logic    o_bit0
);

  weight_t r_data;

  // Load wins over shift so a word-boundary transfer replaces the spent word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_data;
    end else if (i_shift) begin
      r_data <= {1'b0, r_data[WIDTH-1:1]};
    end
  end

  assign o_bit0 = r_data[0];

endmodule

// File: rtl/weight_bit_serializer.sv
// Turns one word of LANES weights per handshake into WIDTH LSB-first bit-planes,
// with a shadow word so consecutive words stream without bubbles.
module weight_bit_serializer
  import accel_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  weight_vec_t       in_weights,
  input  logic              mult_ready,
  output logic              en,
  output logic [LANES-1:0]  weight_bits,
  output logic [IDX_W-1:0]  bit_idx,
  output logic              first,
  output logic              last
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(WIDTH - 1);

  state_t           r_state;
  weight_vec_t      r_shadow;
  logic             r_shadow_full;
  logic             r_in_ready;
  logic [IDX_W-1:0] r_bit_idx;

  logic             w_accept;
  logic             w_advance;
  logic             w_wrap;
  logic             w_transfer;
  logic             w_shadow_full_d;
  logic [LANES-1:0] w_lane_bit0;

  always_comb begin
    w_accept        = in_valid && r_in_ready;
    w_advance       = (r_state == SHIFT) && mult_ready;
    w_wrap          = w_advance && (r_bit_idx == LastIdx);
    w_transfer      = r_shadow_full && ((r_state == IDLE) || w_wrap);
    // Accept needs an empty shadow and transfer a full one, so they never collide.
    w_shadow_full_d = w_transfer ? 1'b0 : (w_accept ? 1'b1 : r_shadow_full);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_shadow      <= '0;
      r_shadow_full <= 1'b0;
      r_in_ready    <= 1'b0;
      r_bit_idx     <= '0;
    end else begin
      if (w_accept) begin
        r_shadow <= in_weights;
      end
      r_shadow_full <= w_shadow_full_d;
      r_in_ready    <= !w_shadow_full_d;

      if (w_transfer) begin
        r_state   <= SHIFT;
        r_bit_idx <= '0;
      end else if (w_wrap) begin
        r_state   <= IDLE;
        r_bit_idx <= '0;
      end else if (w_advance) begin
        r_bit_idx <= r_bit_idx + IDX_W'(1);
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    lane_shifter u_lane_shifter (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_transfer),
      .i_shift (w_advance),
      .i_data  (r_shadow[l]),
      .o_bit0  (w_lane_bit0[l])
    );
  end

  always_comb begin
    en          = (r_state == SHIFT);
    weight_bits = en ? w_lane_bit0 : '0;
    bit_idx     = r_bit_idx;
    first       = en && (r_bit_idx == '0);
    last        = en && (r_bit_idx == LastIdx);
    in_ready    = r_in_ready;
  end

endmodule

// File: tb/tb_weight_bit_serializer.sv
// Self-checking bench: a queue of expected bit-planes per accepted word predicts every output.
module tb_weight_bit_serializer;
  import accel_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             mult_ready = 1'b0;
  weight_vec_t      in_weights = '0;
  logic             in_ready;
  logic             en;
  logic [LANES-1:0] weight_bits;
  logic [IDX_W-1:0] bit_idx;
  logic             first;
  logic             last;

  weight_bit_serializer dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_weights  (in_weights),
    .mult_ready  (mult_ready),
    .en          (en),
    .weight_bits (weight_bits),
    .bit_idx     (bit_idx),
    .first       (first),
    .last        (last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LANES-1:0] plane;
    int               idx;
    int               avail;
  } plane_t;

  localparam int unsigned VW = LANES + IDX_W + 4;

  plane_t          q[$];
  int              cyc = 0;
  int              checks = 0;
  int              errors = 0;
  logic            exp_en = 1'b0;
  logic [VW-1:0]   exp_vec = '0;
  logic [VW-1:0]   obs;

  assign obs = {en, weight_bits, bit_idx, first, last, in_ready};

  function automatic logic [LANES-1:0] plane_of(weight_vec_t w, int j);
    logic [LANES-1:0] p;
    for (int l = 0; l < LANES; l++) p[l] = w[l][j];
    return p;
  endfunction

  // A word's planes become visible the edge after its accept; a word whose plane 0
  // is not yet on the bus is sitting in the shadow and blocks in_ready.
  task automatic model_eval();
    int               waiting;
    int               idx;
    logic [LANES-1:0] bits;
    waiting = 0;
    idx     = 0;
    bits    = '0;
    exp_en  = (q.size() > 0) && (q[0].avail <= cyc);
    if (exp_en) begin
      bits = q[0].plane;
      idx  = q[0].idx;
    end
    foreach (q[i]) if (q[i].idx == 0 && !(i == 0 && exp_en)) waiting++;
    exp_vec = {exp_en, bits, IDX_W'(idx), exp_en && idx == 0, exp_en && idx == WIDTH - 1,
               !rst && waiting == 0};
  endtask

  task automatic step();
    int e;
    e = cyc + 1;
    if (!rst && in_valid && in_ready)
      for (int j = 0; j < WIDTH; j++)
        q.push_back('{plane: plane_of(in_weights, j), idx: j, avail: e + 1});
    if (!rst && exp_en && mult_ready) void'(q.pop_front());
    @(posedge clk);
    cyc++;
    #1;
    if (rst) q.delete();
    model_eval();
  endtask

  function automatic weight_vec_t rand_word();
    weight_vec_t w;
    for (int l = 0; l < LANES; l++) w[l] = WIDTH'($urandom);
    return w;
  endfunction

  task automatic test_reset();
    repeat (3) begin
      step();
      checks++;
      if (obs !== '0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got=%h exp=%h", cyc, obs, {VW{1'b0}});
      end
    end
    rst = 1'b0;
    step();
    checks++;
    if (in_ready !== 1'b1 || obs !== exp_vec) begin
      errors++;
      $display("FAIL reset_release cyc=%0d got=%h exp=%h", cyc, obs, exp_vec);
    end
  endtask

  task automatic test_single_word();
    weight_vec_t w;
    int          n_en;
    for (int l = 0; l < LANES; l++) w[l] = 16'h0400;
    n_en = 0;
    in_weights = w;
    in_valid = 1'b1;
    mult_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL single_word cyc=%0d got=%h exp=%h", cyc, obs, exp_vec);
      end
      if (en) n_en++;
      step();
    end
    checks++;
    if (n_en != 16) begin
      errors++;
      $display("FAIL single_word_en_count got=%0d exp=16", n_en);
    end
  endtask

  task automatic test_identity();
    weight_vec_t w;
    for (int l = 0; l < LANES; l++) w[l] = WIDTH'(1) << l;
    in_weights = w;
    in_valid = 1'b1;
    mult_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL identity cyc=%0d got=%h exp=%h", cyc, obs, exp_vec);
      end
      if (en) begin
        checks++;
        if (weight_bits !== (LANES'(1) << bit_idx)) begin
          errors++;
          $display("FAIL identity_plane idx=%0d got=%h exp=%h", bit_idx, weight_bits,
                   LANES'(1) << bit_idx);
        end
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    weight_vec_t words[2];
    int          wi;
    int          n_en;
    int          first_c;
    int          last_c;
    logic        acc;
    for (int l = 0; l < LANES; l++) begin
      words[0][l] = 16'hAAAA;
      words[1][l] = 16'h5555;
    end
    wi = 0; n_en = 0; first_c = -1; last_c = -1;
    mult_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      in_valid = (wi < 2);
      in_weights = words[(wi < 2) ? wi : 1];
      acc = in_valid && in_ready;
      step();
      if (acc) wi++;
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL back_to_back cyc=%0d got=%h exp=%h", cyc, obs, exp_vec);
      end
      if (en) begin
        n_en++;
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (n_en != 32 || last_c - first_c + 1 != 32) begin
      errors++;
      $display("FAIL back_to_back_stream got=%0d/%0d exp=32/32", n_en, last_c - first_c + 1);
    end
  endtask

  task automatic test_stall();
    int   n_en;
    int   n_idx5;
    int   stall_cnt;
    logic stalled;
    n_en = 0; n_idx5 = 0; stall_cnt = 0; stalled = 1'b0;
    in_weights = rand_word();
    in_valid = 1'b1;
    mult_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL stall cyc=%0d got=%h exp=%h", cyc, obs, exp_vec);
      end
      if (en) n_en++;
      if (en && bit_idx == 5) n_idx5++;
      if (!stalled && en && bit_idx == 5) begin
        mult_ready = 1'b0;
        stall_cnt = 3;
        stalled = 1'b1;
      end else if (stall_cnt > 0) begin
        stall_cnt--;
        if (stall_cnt == 0) mult_ready = 1'b1;
      end
      step();
    end
    checks++;
    if (n_en != 19 || n_idx5 != 4) begin
      errors++;
      $display("FAIL stall_counts got=%0d/%0d exp=19/4", n_en, n_idx5);
    end
  endtask

  task automatic test_reset_mid();
    weight_vec_t words[2];
    int          wi;
    int          n_en;
    logic        acc;
    logic        hit;
    words[0] = rand_word();
    words[1] = rand_word();
    wi = 0; n_en = 0; hit = 1'b0;
    mult_ready = 1'b1;
    for (int i = 0; i < 40 && !hit; i++) begin
      in_valid = (wi < 2);
      in_weights = words[(wi < 2) ? wi : 1];
      acc = in_valid && in_ready;
      step();
      if (acc) wi++;
      if (wi == 2 && exp_en && en && bit_idx == 7) hit = 1'b1;
    end
    in_valid = 1'b0;
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL reset_mid_reach got=%0d exp=7", bit_idx);
    end
    #3;
    rst = 1'b1;
    q.delete();
    #1;
    model_eval();
    checks++;
    if (obs !== '0 || exp_vec !== '0) begin
      errors++;
      $display("FAIL reset_mid_async got=%h exp=%h", obs, {VW{1'b0}});
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL reset_mid_after cyc=%0d got=%h exp=%h", cyc, obs, exp_vec);
      end
      if (en) n_en++;
    end
    checks++;
    if (n_en != 0) begin
      errors++;
      $display("FAIL reset_mid_no_en got=%0d exp=0", n_en);
    end
  endtask

  task automatic test_random();
    logic acc;
    acc = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (acc || !in_valid) begin
        in_valid = ($urandom_range(0, 2) != 0);
        in_weights = rand_word();
      end
      mult_ready = ($urandom_range(0, 3) != 0);
      acc = in_valid && in_ready;
      step();
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs, exp_vec);
      end
    end
    in_valid = 1'b0;
    mult_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL random_drain cyc=%0d got=%h exp=%h", cyc, obs, exp_vec);
      end
    end
    checks++;
    if (en !== 1'b0) begin
      errors++;
      $display("FAIL random_idle got=%b exp=0", en);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_word();
    test_identity();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
